// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU access stage and a debug/loader master.
// CPU wins contention until the debug port has lost MAX_WAIT cycles in a row.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        cpu_be,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,

   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [31:0]       dbg_wdata,
   input  logic [3:0]        dbg_be,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [31:0]       dbg_rdata,

   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned     WcntW   = $clog2(MAX_WAIT + 1);
   localparam logic [WcntW-1:0] WcntMax = WcntW'(MAX_WAIT);

   logic [WcntW-1:0] wcnt_q, wcnt_d;
   logic             rd_pend_q, rd_pend_d;
   logic             rd_owner_q, rd_owner_d;
   logic             cpu_win, dbg_win, sel_we;

   // Grant decision: debug wins when uncontended or once it has waited out the CPU.
   always_comb begin
      dbg_win = ~reset & dbg_req & (~cpu_req | (wcnt_q == WcntMax));
      cpu_win = ~reset & cpu_req & ~dbg_win;
   end

   always_comb begin
      mem_en    = cpu_win | dbg_win;
      mem_we    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = '0;
      sel_we    = 1'b0;
      if (dbg_win) begin
         sel_we    = dbg_we;
         mem_we    = dbg_we ? dbg_be : 4'b0000;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end else if (cpu_win) begin
         sel_we    = cpu_we;
         mem_we    = cpu_we ? cpu_be : 4'b0000;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   always_comb begin
      wcnt_d     = '0;
      rd_pend_d  = mem_en & ~sel_we;
      rd_owner_d = dbg_win & ~sel_we;
      // Counts consecutive cycles the debug port lost to the CPU; any other cycle restarts it.
      if (cpu_req & dbg_req & ~dbg_win) begin
         wcnt_d = wcnt_q + WcntW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wcnt_q     <= '0;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         wcnt_q     <= wcnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   always_comb begin
      cpu_gnt    = cpu_win;
      dbg_gnt    = dbg_win;
      cpu_rvalid = ~reset & rd_pend_q & ~rd_owner_q;
      dbg_rvalid = ~reset & rd_pend_q & rd_owner_q;
      cpu_rdata  = cpu_rvalid ? mem_rdata : 32'h0;
      dbg_rdata  = dbg_rvalid ? mem_rdata : 32'h0;
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed cycle table, reset-mid-read sequence, then random
// traffic against a reference model built from the arbitration rules.
module tb_dmem_port_arbiter;

   localparam int unsigned ADDR_W   = 15;
   localparam int unsigned MAX_WAIT = 4;

   logic              clk;
   logic              reset;
   logic              cpu_req, cpu_we, dbg_req, dbg_we;
   logic [ADDR_W-1:0] cpu_addr, dbg_addr, mem_addr;
   logic [31:0]       cpu_wdata, dbg_wdata, mem_wdata, mem_rdata, cpu_rdata, dbg_rdata;
   logic [3:0]        cpu_be, dbg_be, mem_we;
   logic              cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en;

   int checks   = 0;
   int failures = 0;

   dmem_port_arbiter #(
      .ADDR_W   (ADDR_W),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_be     (cpu_be),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_be     (dbg_be),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory behind the arbiter (environment) and the model's own copy of its contents.
   logic [31:0] tbmem  [0:(1<<ADDR_W)-1];
   logic [31:0] mdl_mem[0:(1<<ADDR_W)-1];

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we == 4'b0000) begin
            mem_rdata <= tbmem[mem_addr];
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (mem_we[b]) tbmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 50)
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   typedef struct {
      logic              c_req, c_we;
      logic [ADDR_W-1:0] c_addr;
      logic              d_req, d_we;
      logic [ADDR_W-1:0] d_addr;
      logic [31:0]       d_wdata;
      logic [3:0]        d_be;
      logic [1:0]        e_gnt;   // {cpu, dbg}
      logic [3:0]        e_mwe;
      logic [ADDR_W-1:0] e_maddr;
      logic [1:0]        e_rv;    // {cpu, dbg}
      logic [31:0]       e_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                      input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                      input logic [31:0] dwd, input logic [3:0] dbe, input logic [1:0] g,
                      input logic [3:0] mwe, input logic [ADDR_W-1:0] ma,
                      input logic [1:0] rv, input logic [31:0] rd);
      vec_t v;
      v.c_req = cr; v.c_we = cw; v.c_addr = ca;
      v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dwd; v.d_be = dbe;
      v.e_gnt = g; v.e_mwe = mwe; v.e_maddr = ma; v.e_rv = rv; v.e_rdata = rd;
      vecs.push_back(v);
   endtask

   task automatic both_rd(input logic [1:0] g, input logic [1:0] rv, input logic [31:0] rd);
      add(1, 0, 15'h020, 1, 0, 15'h030, 32'h0, 4'h0, g, 4'h0,
          (g == 2'b01) ? 15'h030 : 15'h020, rv, rd);
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = 4'hF;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_be = 4'h0;
   endtask

   task automatic chk_all_quiet(input string tag);
      chk({tag, "_cpu_gnt"}, 32'(cpu_gnt), 0);
      chk({tag, "_dbg_gnt"}, 32'(dbg_gnt), 0);
      chk({tag, "_mem_en"}, 32'(mem_en), 0);
      chk({tag, "_mem_we"}, 32'(mem_we), 0);
      chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 0);
      chk({tag, "_dbg_rvalid"}, 32'(dbg_rvalid), 0);
      chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
      chk({tag, "_dbg_rdata"}, dbg_rdata, 0);
   endtask

   // Reference model state
   int          losses;
   logic        pend, pend_owner;
   logic [31:0] pend_data;

   initial begin
      logic [31:0] w7fff;
      logic        c_act, d_act, c_gprev, d_gprev, exp_c, exp_d, sw;
      logic [3:0]  exp_we;
      logic [ADDR_W-1:0] exp_addr;
      logic [31:0] exp_wd;

      for (int i = 0; i < (1 << ADDR_W); i++) begin
         tbmem[i]   = 32'hA5A50000 ^ 32'(i);
         mdl_mem[i] = 32'hA5A50000 ^ 32'(i);
      end
      tbmem[16]   = 32'h12345678;
      mdl_mem[16] = 32'h12345678;
      mem_rdata   = 32'h0;
      w7fff       = 32'hA5A5CCFF;

      // Directed cycle table, one row per clock, starting right after reset release.
      add(1, 0, 15'h010, 0, 0, 15'h0, 32'h0, 4'h0, 2'b10, 4'h0, 15'h010, 2'b00, 32'h0);
      add(0, 0, 15'h0, 0, 0, 15'h0, 32'h0, 4'h0, 2'b00, 4'h0, 15'h0, 2'b10, 32'h12345678);
      both_rd(2'b10, 2'b00, 32'h0);
      for (int k = 0; k < 3; k++) both_rd(2'b10, 2'b10, 32'hA5A50020);
      both_rd(2'b01, 2'b10, 32'hA5A50020);
      both_rd(2'b10, 2'b01, 32'hA5A50030);
      for (int k = 0; k < 3; k++) both_rd(2'b10, 2'b10, 32'hA5A50020);
      both_rd(2'b01, 2'b10, 32'hA5A50020);
      add(0, 0, 15'h0, 1, 1, 15'h7FFF, 32'hAABBCCDD, 4'b0010, 2'b01, 4'b0010, 15'h7FFF,
          2'b01, 32'hA5A50030);
      add(0, 0, 15'h0, 0, 0, 15'h0, 32'h0, 4'h0, 2'b00, 4'h0, 15'h0, 2'b00, 32'h0);
      add(1, 0, 15'h7FFF, 0, 0, 15'h0, 32'h0, 4'h0, 2'b10, 4'h0, 15'h7FFF, 2'b00, 32'h0);
      add(0, 0, 15'h0, 1, 0, 15'h020, 32'h0, 4'h0, 2'b01, 4'h0, 15'h020, 2'b10, w7fff);
      add(0, 0, 15'h0, 0, 0, 15'h0, 32'h0, 4'h0, 2'b00, 4'h0, 15'h0, 2'b01, 32'hA5A50020);
      both_rd(2'b10, 2'b00, 32'h0);
      both_rd(2'b10, 2'b10, 32'hA5A50020);
      both_rd(2'b10, 2'b10, 32'hA5A50020);
      add(1, 0, 15'h020, 0, 0, 15'h030, 32'h0, 4'h0, 2'b10, 4'h0, 15'h020, 2'b10,
          32'hA5A50020);
      for (int k = 0; k < 4; k++) both_rd(2'b10, 2'b10, 32'hA5A50020);
      both_rd(2'b01, 2'b10, 32'hA5A50020);
      add(0, 0, 15'h0, 0, 0, 15'h0, 32'h0, 4'h0, 2'b00, 4'h0, 15'h0, 2'b01, 32'hA5A50030);
      mdl_mem[15'h7FFF] = w7fff;

      // Outputs forced low while reset is held, even with both ports requesting writes.
      idle_inputs();
      cpu_req = 1; cpu_we = 1; dbg_req = 1; dbg_we = 1; dbg_be = 4'hF;
      reset = 1;
      #2;
      chk_all_quiet("reset_hold");
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      idle_inputs();

      foreach (vecs[i]) begin
         cpu_req = vecs[i].c_req; cpu_we = vecs[i].c_we; cpu_addr = vecs[i].c_addr;
         dbg_req = vecs[i].d_req; dbg_we = vecs[i].d_we; dbg_addr = vecs[i].d_addr;
         dbg_wdata = vecs[i].d_wdata; dbg_be = vecs[i].d_be;
         @(negedge clk);
         chk($sformatf("tbl%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(vecs[i].e_gnt[1]));
         chk($sformatf("tbl%0d_dbg_gnt", i), 32'(dbg_gnt), 32'(vecs[i].e_gnt[0]));
         chk($sformatf("tbl%0d_mem_en", i), 32'(mem_en), 32'(|vecs[i].e_gnt));
         chk($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_mwe));
         chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_maddr));
         chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata,
             (vecs[i].e_gnt == 2'b01) ? vecs[i].d_wdata : 32'h0);
         chk($sformatf("tbl%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(vecs[i].e_rv[1]));
         chk($sformatf("tbl%0d_dbg_rvalid", i), 32'(dbg_rvalid), 32'(vecs[i].e_rv[0]));
         chk($sformatf("tbl%0d_cpu_rdata", i), cpu_rdata,
             vecs[i].e_rv[1] ? vecs[i].e_rdata : 32'h0);
         chk($sformatf("tbl%0d_dbg_rdata", i), dbg_rdata,
             vecs[i].e_rv[0] ? vecs[i].e_rdata : 32'h0);
         @(posedge clk);
         #1;
      end

      // Reset arriving while a CPU read is in flight must swallow its rvalid.
      idle_inputs();
      cpu_req = 1; cpu_addr = 15'h010;
      @(negedge clk);
      chk("rstmid_grant", 32'(cpu_gnt), 1);
      @(posedge clk);
      #1;
      reset = 1;
      #1;
      chk_all_quiet("rstmid_during");
      @(posedge clk);
      #1;
      reset = 0;
      cpu_req = 0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rstmid_after_cpu_rvalid", 32'(cpu_rvalid), 0);
         chk("rstmid_after_cpu_rdata", cpu_rdata, 0);
         chk("rstmid_after_dbg_rvalid", 32'(dbg_rvalid), 0);
      end
      @(posedge clk);
      #1;

      // Random traffic; requesters hold their request until the model says it was granted.
      losses = 0; pend = 0; pend_owner = 0; pend_data = 0;
      c_act = 0; d_act = 0; c_gprev = 0; d_gprev = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!c_act || c_gprev) begin
            c_act     = ($urandom_range(0, 3) != 0);
            cpu_we    = ($urandom_range(0, 2) == 0);
            cpu_addr  = ADDR_W'(15'h100 + $urandom_range(0, 15));
            cpu_wdata = $urandom;
            cpu_be    = 4'($urandom_range(0, 15));
         end
         if (!d_act || d_gprev) begin
            d_act     = ($urandom_range(0, 5) != 0);
            dbg_we    = ($urandom_range(0, 1) == 0);
            dbg_addr  = ADDR_W'(15'h100 + $urandom_range(0, 15));
            dbg_wdata = $urandom;
            dbg_be    = 4'($urandom_range(0, 15));
         end
         // Occasional debug withdrawal while still waiting.
         if (d_act && !d_gprev && $urandom_range(0, 19) == 0) d_act = 0;
         cpu_req = c_act;
         dbg_req = d_act;

         // Debug goes through uncontended, or after losing MAX_WAIT cycles in a row.
         exp_d    = d_act && (!c_act || losses == int'(MAX_WAIT));
         exp_c    = c_act && !exp_d;
         sw       = exp_d ? dbg_we : cpu_we;
         exp_we   = 4'h0;
         exp_addr = '0;
         exp_wd   = 32'h0;
         if (exp_d || exp_c) begin
            exp_addr = exp_d ? dbg_addr : cpu_addr;
            exp_wd   = exp_d ? dbg_wdata : cpu_wdata;
            if (sw) exp_we = exp_d ? dbg_be : cpu_be;
         end

         @(negedge clk);
         chk("rnd_cpu_gnt", 32'(cpu_gnt), 32'(exp_c));
         chk("rnd_dbg_gnt", 32'(dbg_gnt), 32'(exp_d));
         chk("rnd_mem_en", 32'(mem_en), 32'(exp_c | exp_d));
         chk("rnd_mem_we", 32'(mem_we), 32'(exp_we));
         chk("rnd_mem_addr", 32'(mem_addr), 32'(exp_addr));
         chk("rnd_mem_wdata", mem_wdata, exp_wd);
         chk("rnd_cpu_rvalid", 32'(cpu_rvalid), 32'(pend && !pend_owner));
         chk("rnd_dbg_rvalid", 32'(dbg_rvalid), 32'(pend && pend_owner));
         chk("rnd_cpu_rdata", cpu_rdata, (pend && !pend_owner) ? pend_data : 32'h0);
         chk("rnd_dbg_rdata", dbg_rdata, (pend && pend_owner) ? pend_data : 32'h0);

         pend = 0;
         if ((exp_c || exp_d) && !sw) begin
            pend       = 1;
            pend_owner = exp_d;
            pend_data  = mdl_mem[exp_addr];
         end else if ((exp_c || exp_d) && sw) begin
            for (int b = 0; b < 4; b++)
               if (exp_we[b]) mdl_mem[exp_addr][8*b +: 8] = exp_wd[8*b +: 8];
         end
         losses  = (c_act && d_act && !exp_d) ? losses + 1 : 0;
         c_gprev = exp_c;
         d_gprev = exp_d;

         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
